// File: rtl/spi_master_pkg.sv
// Shared FSM state type and default sizing for the pixel SPI master.
package spi_master_pkg;

  localparam int DEF_TX_BITS = 24;
  localparam int DEF_RX_BITS = 8;
  localparam int DEF_CLK_DIV = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_GUARD
  } state_t;

endpackage

// File: rtl/spi_sck_divider.sv
// Half-period tick generator: o_tick marks the last clk cycle of each CLK_DIV-long phase.
// Counter restarts on frame acceptance so every frame begins phase-aligned.
module spi_sck_divider
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  input  logic i_run,
  output logic o_tick
);

  logic [7:0] r_cnt;

  assign o_tick = i_run && (r_cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_px_master.sv
// Mode-0 SPI master: one TX_BITS frame per accepted pixel, busy CLK_DIV*(2*TX_BITS+2) cycles, no queueing.
// Optional SPI_MASTER_LOOPBACK_EN adds loopback_i, which samples internal MOSI instead of spi_sdi_i.
module spi_px_master
  import spi_master_pkg::*;
#(
  parameter int TX_BITS = DEF_TX_BITS,
  parameter int RX_BITS = DEF_RX_BITS,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [TX_BITS-1:0] tx_px_i,
  input  logic               tx_valid_i,
  output logic               tx_ready_o,
  output logic [RX_BITS-1:0] rx_px_o,
  output logic               rx_valid_o,
  output logic               spi_sck_o,
  output logic               spi_cs_o,
  output logic               spi_sdo_o,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic               loopback_i,
`endif
  input  logic               spi_sdi_i
);

  localparam int BW = (TX_BITS > 1) ? $clog2(TX_BITS) : 1;

  state_t             r_state;
  state_t             w_state_nx;
  logic [BW-1:0]      r_bit;
  logic [TX_BITS-1:0] r_tx;
  logic [RX_BITS-1:0] r_rx;
  logic [RX_BITS-1:0] r_rx_px;
  logic               r_rx_vld;
  logic               w_tick;
  logic               w_accept;
  logic               w_last;
  logic               w_enter_high;
  logic               w_enter_low;
  logic               w_enter_guard;
  logic               w_miso;

  spi_sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .i_clk     (clk_i),
    .i_rst     (reset_i),
    .i_restart (w_accept),
    .i_run     (r_state != ST_IDLE),
    .o_tick    (w_tick)
  );

  assign w_accept      = (r_state == ST_IDLE) && tx_valid_i;
  assign w_last        = (r_bit == BW'(TX_BITS - 1));
  assign w_enter_high  = (w_state_nx == ST_HIGH) && (r_state != ST_HIGH);
  assign w_enter_low   = (w_state_nx == ST_LOW) && (r_state != ST_LOW);
  assign w_enter_guard = (w_state_nx == ST_GUARD) && (r_state != ST_GUARD);

`ifdef SPI_MASTER_LOOPBACK_EN
  assign w_miso = loopback_i ? r_tx[TX_BITS-1] : spi_sdi_i;
`else
  assign w_miso = spi_sdi_i;
`endif

  always_comb begin
    w_state_nx = r_state;
    tx_ready_o = 1'b0;
    spi_sck_o  = 1'b0;
    spi_cs_o   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        tx_ready_o = 1'b1;
        spi_cs_o   = 1'b1;
        if (tx_valid_i) w_state_nx = ST_SETUP;
      end
      ST_SETUP: if (w_tick) w_state_nx = ST_HIGH;
      ST_HIGH: begin
        spi_sck_o = 1'b1;
        if (w_tick) w_state_nx = ST_LOW;
      end
      ST_LOW:   if (w_tick) w_state_nx = w_last ? ST_GUARD : ST_HIGH;
      ST_GUARD: begin
        spi_cs_o = 1'b1;
        if (w_tick) w_state_nx = ST_IDLE;
      end
      default: begin
        spi_cs_o   = 1'b1;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // MOSI is the MSB of the shift register, forced low whenever the slave is deselected.
  assign spi_sdo_o  = !spi_cs_o && r_tx[TX_BITS-1];
  assign rx_px_o    = r_rx_px;
  assign rx_valid_o = r_rx_vld;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= ST_IDLE;
      r_bit    <= '0;
      r_tx     <= '0;
      r_rx     <= '0;
      r_rx_px  <= '0;
      r_rx_vld <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_rx_vld <= w_enter_guard;
      if (w_accept) begin
        r_tx  <= tx_px_i;
        r_bit <= '0;
      end else begin
        if (w_enter_low) r_tx <= {r_tx[TX_BITS-2:0], 1'b0};
        if (w_enter_high && (r_state == ST_LOW)) r_bit <= r_bit + BW'(1);
      end
      if (w_enter_high) r_rx <= {r_rx[RX_BITS-2:0], w_miso};
      if (w_enter_guard) r_rx_px <= r_rx;
    end
  end

endmodule

// File: doc/spi_px_master.md
SPI_PX_MASTER -- requirements
Module: spi_px_master

Interface
REQ-001 Parameter TX_BITS, default 24, sets pixel bits sent per frame and the frame length in SCK cycles.
REQ-002 Parameter RX_BITS, default 8, sets result bits returned per frame; RX_BITS <= TX_BITS.
REQ-003 Parameter CLK_DIV, default 2, sets clk_i cycles per SCK half-period; legal range is 1..255.
REQ-004 Port clk_i, input, 1 bit: single clock; all logic is on the rising edge.
REQ-005 Port reset_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port tx_px_i, input, TX_BITS: pixel to transmit, MSB first.
REQ-007 Port tx_valid_i, input, 1 bit: request to start a frame.
REQ-008 Port tx_ready_o, output, 1 bit: block is idle and can accept a frame.
REQ-009 Port rx_px_o, output, RX_BITS: result captured from the last RX_BITS bits of the frame.
REQ-010 Port rx_valid_o, output, 1 bit: single-cycle pulse marking a new rx_px_o.
REQ-011 Port spi_sck_o, output, 1 bit: SPI clock, idle low (CPOL=0).
REQ-012 Port spi_cs_o, output, 1 bit: chip select, active low.
REQ-013 Port spi_sdo_o, output, 1 bit: MOSI.
REQ-014 Port spi_sdi_i, input, 1 bit: MISO.

Function
REQ-015 SPI mode 0: MOSI changes only while SCK is low; MISO is sampled on the clk_i edge that raises SCK.
REQ-016 A frame is accepted on a rising clk_i edge when tx_valid_i=1 and tx_ready_o=1; tx_px_i is latched on that edge.
REQ-017 FSM states: IDLE -> SETUP -> (HIGH <-> LOW) x TX_BITS -> GUARD -> IDLE; each non-IDLE state lasts exactly CLK_DIV cycles.
REQ-018 SETUP behaviour: cs=0, sck=0, MOSI=bit TX_BITS-1.
REQ-019 HIGH behaviour: sck=1; MISO is shifted into the receive register on entry to HIGH.
REQ-020 LOW behaviour: sck=0; MOSI advances to the next bit on entry to LOW; the last LOW exits to GUARD.
REQ-021 GUARD behaviour: cs=1, sck=0; rx_valid_o pulses in the first GUARD cycle; rx_px_o updates in that same cycle.
REQ-022 tx_ready_o=1 only in IDLE; busy time per frame is CLK_DIV*(2*TX_BITS+2) cycles from acceptance to tx_ready_o=1.
REQ-023 tx_valid_i while busy is ignored; no queueing; back-to-back frames are accepted in the first IDLE cycle.
REQ-024 rx_px_o holds its value between frames; it changes only with rx_valid_o.
REQ-025 spi_sdo_o=0 whenever cs=1.
REQ-026 A bit counter wraps only via the FSM; no frame exceeds TX_BITS SCK pulses.

Reset
REQ-027 While reset_i=1, regardless of clock: state=IDLE, cs=1, sck=0, sdo=0, rx_valid_o=0, rx_px_o=0, tx_ready_o=1.
REQ-028 Reset mid-frame aborts the frame immediately with no rx_valid_o pulse; the next frame starts clean after reset release.

Configuration
REQ-029 The macro SPI_MASTER_LOOPBACK_EN adds an input port loopback_i (1 bit).
REQ-030 With SPI_MASTER_LOOPBACK_EN defined and loopback_i=1, received bits are taken from internal MOSI instead of spi_sdi_i, so rx_px_o equals tx_px_i[RX_BITS-1:0].
REQ-031 Without SPI_MASTER_LOOPBACK_EN, no port and no mux exist; sampling always uses spi_sdi_i.

Structure
REQ-032 Package spi_master_pkg holds the FSM state enum typedef and the default TX_BITS, RX_BITS and CLK_DIV constants.
REQ-033 Sub-module spi_sck_divider generates a one-cycle half-period tick every CLK_DIV cycles, restarted on frame acceptance.

Verification
REQ-034 Scenario 1 (CLK_DIV=2): send 24'hA50FC3 while the slave model drives 8'h3C in the last 8 bits -> MOSI shows A50FC3 MSB first; 24 SCK pulses; rx_px_o=8'h3C with a 1-cycle rx_valid_o pulse; tx_ready_o returns 100 cycles after acceptance.
REQ-035 Scenario 2: tx_valid_i held high continuously -> frames are separated by exactly one IDLE cycle; each frame has cs=1 for at least CLK_DIV cycles in GUARD.
REQ-036 Scenario 3: pulse tx_valid_i during SETUP and mid-frame -> ignored; exactly one frame occurs.
REQ-037 Scenario 4: assert reset_i during bit 10 -> cs=1 and sck=0 in the same cycle; no rx_valid_o pulse; the next frame with 24'h000001 completes correctly.
REQ-038 Scenario 5 (SPI_MASTER_LOOPBACK_EN defined, loopback_i=1): send 24'h1234AB with spi_sdi_i tied to 1 -> rx_px_o=8'hAB.
REQ-039 Scenario 6 (CLK_DIV=1): send 24'hFFFFFF -> SCK period is 2 cycles and busy time is 50 cycles.
